tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer: the receive end of the 4:1 channel multiplexer. It accepts a serial stream of WIDTH-bit slots, one channel per slot, with a sync flag on slot 0. It steers each slot into its channel register and presents a complete, coherent 4-channel frame on the parallel outputs with a one-cycle valid strobe. It sits between the serial link and the per-channel consumers and owns frame alignment and sync-loss recovery.

---
 rtl/tdm_demux4.sv | 152 +++++++++++++++
 tb/tb_tdm_demux4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns on the slot-0 sync flag, gathers four slots
// and publishes whole frames on Y. Optional saturating error counter: TDM_DEMUX_ERRCNT_EN.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sync,
  output logic [4*WIDTH-1:0]   Y,
  output logic                 frame_valid,
  output logic [1:0]           sel,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       slot_cnt, cnt_nxt;
  logic [WIDTH-1:0] sh0, sh1, sh2;

  logic       sh0_we, sh1_we, sh2_we;
  logic       y_load;
  logic       err_set;
  logic       early_sync;
  logic       missing_sync;

  // A sync flag is only meaningful on a beat, and only contradicts the count once locked.
  assign early_sync   = in_valid && (state == LOCKED) && in_sync  && (slot_cnt != 2'd0);
  assign missing_sync = in_valid && (state == LOCKED) && !in_sync && (slot_cnt == 2'd0);

`ifdef TDM_DEMUX_ERRCNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    cnt_nxt   = slot_cnt;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sync) begin
            state_nxt = LOCKED;
            cnt_nxt   = 2'd1;
          end
        end
        LOCKED: begin
          if (early_sync) begin
            cnt_nxt = 2'd1;
          end else if (missing_sync) begin
            state_nxt = HUNT;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = slot_cnt + 2'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // ---- output / datapath-control decode ----
  always_comb begin
    sh0_we  = 1'b0;
    sh1_we  = 1'b0;
    sh2_we  = 1'b0;
    y_load  = 1'b0;
    err_set = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          sh0_we = in_sync;
        end
        LOCKED: begin
          if (early_sync) begin
            // Partial frame is abandoned; this beat restarts the frame as slot 0.
            err_set = 1'b1;
            sh0_we  = 1'b1;
          end else if (missing_sync) begin
            err_set = 1'b1;
          end else begin
            case (slot_cnt)
              2'd0:    sh0_we = 1'b1;
              2'd1:    sh1_we = 1'b1;
              2'd2:    sh2_we = 1'b1;
              default: y_load = 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // ---- state and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot_cnt    <= 2'd0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot_cnt    <= cnt_nxt;
      frame_valid <= y_load;
      sync_err    <= err_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      Y   <= '0;
    end else begin
      if (sh0_we) sh0 <= in_data;
      if (sh1_we) sh1 <= in_data;
      if (sh2_we) sh2 <= in_data;
      if (y_load) Y   <= {in_data, sh2, sh1, sh0};
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_set) begin
      err_count <= sat_inc8(err_count);
    end
  end
`endif

  assign sel    = slot_cnt;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (WIDTH=4): directed scenarios plus random traffic against a
// queue-based frame model.
module tb_tdm_demux4;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sync  = 1'b0;
  logic [W-1:0]  in_data  = '0;
  logic [4*W-1:0] Y;
  logic          frame_valid;
  logic [1:0]    sel;
  logic          locked;
  logic          sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_sync(in_sync),
    .Y(Y),
    .frame_valid(frame_valid),
    .sel(sel),
    .locked(locked),
    .sync_err(sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the partial frame is the list of slots collected so far.
  logic [W-1:0]   mq[$];
  bit             mlock = 0;
  logic [4*W-1:0] my = '0;
  bit             mfv = 0;
  bit             merr = 0;
  int             mec = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic check_all();
    chk("Y", 32'(Y), 32'(my));
    chk("frame_valid", 32'(frame_valid), 32'(mfv));
    chk("sync_err", 32'(sync_err), 32'(merr));
    chk("locked", 32'(locked), 32'(mlock));
    chk("sel", 32'(sel), 32'(mq.size()));
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(mec));
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    mlock = 0; my = '0; mfv = 0; merr = 0; mec = 0;
  endtask

  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    in_valid = v; in_sync = s; in_data = d;
    mfv = 0; merr = 0;
    if (v) begin
      if (!mlock) begin
        if (s) begin mq.delete(); mq.push_back(d); mlock = 1; end
      end else if (s && mq.size() != 0) begin
        merr = 1; mq.delete(); mq.push_back(d);
      end else if (!s && mq.size() == 0) begin
        merr = 1; mlock = 0;
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          my  = {mq[3], mq[2], mq[1], mq[0]};
          mfv = 1;
          mq.delete();
        end
      end
    end
    if (merr && mec < 255) mec++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frame4(input logic [W-1:0] a, b, c, d, input int gap);
    beat(1, 1, a); repeat (gap) beat(0, 0, 4'h0);
    beat(1, 0, b); repeat (gap) beat(0, 0, 4'h0);
    beat(1, 0, c); repeat (gap) beat(0, 0, 4'h0);
    beat(1, 0, d);
  endtask

  initial begin
    // reset then idle
    #12;
    chk("rst_Y", 32'(Y), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) beat(0, 0, 4'h0);

    // contiguous frames
    frame4(4'h1, 4'h2, 4'h3, 4'h4, 0);
    chk("frame1_const", 32'(Y), 32'h4321);
    frame4(4'h5, 4'h6, 4'h7, 4'h8, 0);
    chk("frame2_const", 32'(Y), 32'h8765);

    // gapped frame: sel must hold across gaps
    frame4(4'h1, 4'h2, 4'h3, 4'h4, 2);
    chk("gap_const", 32'(Y), 32'h4321);

    // early sync
    beat(1, 1, 4'hA); beat(1, 0, 4'hB);
    beat(1, 1, 4'hC);
    chk("early_err_const", 32'(sync_err), 32'h1);
    beat(1, 0, 4'hD); beat(1, 0, 4'hE); beat(1, 0, 4'hF);
    chk("early_const", 32'(Y), 32'hFEDC);

    // missing sync, then relock
    beat(1, 0, 4'h3);
    chk("miss_lock_const", 32'(locked), 32'h0);
    beat(0, 0, 4'h0);
    frame4(4'h9, 4'hA, 4'hB, 4'hC, 0);
    chk("relock_const", 32'(Y), 32'hCBA9);

    // asynchronous reset mid-frame
    beat(1, 1, 4'h7); beat(1, 0, 4'h6);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    frame4(4'h2, 4'h4, 4'h6, 4'h8, 1);
    chk("post_rst_const", 32'(Y), 32'h8642);

`ifdef TDM_DEMUX_ERRCNT_EN
    // 301 consecutive sync beats: every beat after the first is an early sync
    for (int i = 0; i < 301; i++) beat(1, 1, 4'(i));
    chk("errcnt_sat_const", 32'(err_count), 32'd255);
`endif

    // random traffic: mostly well-formed with occasional framing faults
    for (int i = 0; i < 3000; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (mq.size() == 0);
      if ($urandom_range(0, 19) == 0) s = !s;
      beat(v, s, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
